truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE, default 0, meaning extra wait cycles (0..3) held on each minterm before y_in is sampled.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, meaning a one-cycle scan request.
REQ-005 The block SHALL have port y_in, input, 1, meaning the combinational output of the 4-input function under test.
REQ-006 The block SHALL have ports a, b, c, d, outputs, 1 each, meaning the registered minterm index, with a as MSB and d as LSB, driven to the function's select inputs.
REQ-007 The block SHALL have port en, output, 1, meaning the registered decoder enable for the function under test.
REQ-008 The block SHALL have port busy, output, 1, meaning a scan is in progress.
REQ-009 The block SHALL have port done, output, 1, meaning a one-cycle pulse marking scan completion.
REQ-010 The block SHALL have port table, output, 16, meaning the captured truth table, where bit i = y at minterm i.
REQ-011 The block SHALL have port ones_count, output, 5, meaning the number of set bits in table (0..16).

Function
REQ-012 The block SHALL implement the FSM states IDLE, DRIVE, WAIT, SAMPLE, FIN.
REQ-013 In IDLE with start=1, the block SHALL go to DRIVE, set idx=0, and clear table and ones_count.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-015 DRIVE SHALL last one cycle with {a,b,c,d}=idx and en=1; it SHALL then go to WAIT if SETTLE>0, else to SAMPLE.
REQ-016 WAIT SHALL last exactly SETTLE cycles with a..d and en held, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle, write y_in into table[idx], and add y_in to ones_count at its closing edge.
REQ-018 From SAMPLE, if idx=15 the block SHALL go to FIN; otherwise it SHALL increment idx and return to DRIVE.
REQ-019 idx is 4 bits and SHALL never wrap during a scan, since idx=15 exits to FIN.
REQ-020 In FIN, done SHALL be 1 for exactly one cycle and en SHALL be 0; the block SHALL then go to IDLE.
REQ-021 busy SHALL be 1 in DRIVE, WAIT, SAMPLE, and FIN, and 0 in IDLE.
REQ-022 en SHALL be 1 only in DRIVE, WAIT, and SAMPLE.
REQ-023 a..d SHALL hold their last value while en=0.
REQ-024 start SHALL be ignored whenever busy=1; there is no queuing and no restart.
REQ-025 table and ones_count SHALL hold their final values from FIN until the next accepted start.
REQ-026 Scan latency SHALL be 16*(2+SETTLE) cycles from the first DRIVE cycle to the FIN cycle inclusive of SAMPLE; done SHALL assert on cycle 16*(2+SETTLE)+1 after the start-accept edge.
REQ-027 start=1 in the same cycle as FIN SHALL be ignored; a new scan requires start in IDLE.
REQ-028 y_in SHALL be sampled only in SAMPLE; its value in all other states SHALL have no effect.

Reset
REQ-029 While rst=1, the block SHALL immediately force state=IDLE, idx=0, {a,b,c,d}=0, en=0, busy=0, done=0, table=16'h0000, and ones_count=0, regardless of clk.
REQ-030 Reset asserted mid-scan SHALL abort the scan and discard partial results; no done pulse SHALL be produced.
REQ-031 After rst deasserts, the block SHALL accept start on the first clk edge.

Verification
REQ-032 Bench SHALL cover: SETTLE=0, y_in driven by the prime-minterm function (2,3,5,7,11,13), pulse start -> done at cycle 33, table=16'h28AC, ones_count=6, busy low the cycle after done.
REQ-033 Bench SHALL cover: SETTLE=2, y_in tied 1 -> done at cycle 65, table=16'hFFFF, ones_count=16 (no 5-bit overflow).
REQ-034 Bench SHALL cover: y_in tied 0, then start pulsed again during the scan at cycle 10 -> single done only, table=16'h0000, ones_count=0.
REQ-035 Bench SHALL cover: rst asserted asynchronously at cycle 12 of a prime scan -> all outputs zero at once, no done, fresh start -> table=16'h28AC.
REQ-036 Bench SHALL cover: y_in toggling outside SAMPLE cycles while the function output is 0 in SAMPLE -> table=16'h0000.
REQ-037 Bench SHALL cover: back-to-back scans, start in the FIN cycle then in IDLE -> FIN-cycle start ignored; second scan runs, with table held between scans.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks a 4-input function through all 16 minterms,
// samples its output per minterm and reports the captured table and popcount.
module truth_table_scanner #(
  parameter int SETTLE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        y_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_count,
  output logic [2:0]  dbg_state
);

  // Handshake: start is a single-cycle request honoured only while busy=0;
  // done pulses for one cycle in FIN, after which table_out/ones_count hold.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_LAST = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  ones_q, ones_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 2'd0;
      table_q <= 16'h0000;
      ones_q  <= 5'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 4'd0;
          table_d = 16'h0000;
          ones_d  = 5'd0;
        end
      end
      DRIVE: begin
        if (SETTLE > 0) begin
          state_d = WAIT;
          cnt_d   = WAIT_LAST;
        end else begin
          state_d = SAMPLE;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      SAMPLE: begin
        table_d[idx_q] = y_in;
        ones_d         = ones_q + {4'd0, y_in};
        // idx=15 leaves the loop, so idx never wraps within a scan
        if (idx_q == 4'hF) begin
          state_d = FIN;
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_comb begin
    en_d   = (state_d == DRIVE) || (state_d == WAIT) || (state_d == SAMPLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // The minterm lines follow idx, which only moves while en=1.
  assign {a, b, c, d} = idx_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign ones_count = ones_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: directed scans on a SETTLE=0 and a SETTLE=2
// instance, with a done-driven scoreboard checking table, popcount and latency.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start2;
  logic        y0, y2;
  logic        a0, b0, c0, d0, en0, busy0, done0;
  logic        a2, b2, c2, d2, en2, busy2, done2;
  logic [15:0] tbl0, tbl2;
  logic [4:0]  ones0, ones2;
  logic [2:0]  dbg0, dbg2;

  int total = 0;
  int bad   = 0;

  // packed expectation: {done_cycle[7:0], ones[4:0], table[15:0]}
  logic [28:0] exp0_q[$];
  logic [28:0] exp2_q[$];

  int          mode0;
  logic        tog;
  logic [15:0] prime_tt;

  truth_table_scanner #(.SETTLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .y_in(y0),
    .a(a0), .b(b0), .c(c0), .d(d0), .en(en0), .busy(busy0), .done(done0),
    .table_out(tbl0), .ones_count(ones0), .dbg_state(dbg0)
  );

  truth_table_scanner #(.SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .y_in(y2),
    .a(a2), .b(b2), .c(c2), .d(d2), .en(en2), .busy(busy2), .done(done2),
    .table_out(tbl2), .ones_count(ones2), .dbg_state(dbg2)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- function under test models ----------------
  always @(negedge clk) tog <= ~tog;

  always_comb begin
    y0 = 1'b0;
    case (mode0)
      0: y0 = prime_tt[{a0, b0, c0, d0}];
      1: y0 = 1'b1;
      2: y0 = 1'b0;
      3: y0 = (dbg0 == 3'd3) ? 1'b0 : tog;
      default: y0 = 1'b0;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [28:0] pack(input int cyc, input int ones, input logic [15:0] t);
    return {8'(cyc), 5'(ones), t};
  endfunction

  task automatic start_scan(input int which);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which == 0) ? busy0 : busy2) && n < 300);
    check("scan_timeout", (which == 0) ? busy0 : busy2, 0);
  endtask

  task automatic wait_fin0();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done0 && n < 300);
    check("fin_timeout", done0, 1);
  endtask

  // ---------------- monitors / scoreboard ----------------
  int   cyc0 = 0, cyc2 = 0;
  logic post0 = 1'b0, post2 = 1'b0;

  always @(negedge clk) begin
    logic [28:0] e;
    if (rst) begin
      cyc0  = 0;
      post0 = 1'b0;
    end else begin
      if (post0) begin
        check("busy_after_done0", busy0, 0);
        post0 = 1'b0;
      end
      if (busy0) cyc0++; else cyc0 = 0;
      if (done0) begin
        if (exp0_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done0 actual=1 required=0");
        end else begin
          e = exp0_q.pop_front();
          check("done_cycle0", cyc0, e[28:21]);
          check("table0", tbl0, e[15:0]);
          check("ones0", ones0, e[20:16]);
        end
        post0 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [28:0] e;
    if (rst) begin
      cyc2  = 0;
      post2 = 1'b0;
    end else begin
      if (post2) begin
        check("busy_after_done2", busy2, 0);
        post2 = 1'b0;
      end
      if (busy2) cyc2++; else cyc2 = 0;
      if (done2) begin
        if (exp2_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done2 actual=1 required=0");
        end else begin
          e = exp2_q.pop_front();
          check("done_cycle2", cyc2, e[28:21]);
          check("table2", tbl2, e[15:0]);
          check("ones2", ones2, e[20:16]);
        end
        post2 = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start0   = 1'b0;
    start2   = 1'b0;
    y2       = 1'b1;
    tog      = 1'b0;
    mode0    = 0;
    prime_tt = 16'h28AC;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_abcd", {a0, b0, c0, d0}, 0);
    check("rst_en", en0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_table", tbl0, 0);
    check("rst_ones", ones0, 0);
    check("rst_busy2", busy2, 0);
    rst = 1'b0;

    // prime function, SETTLE=0
    mode0 = 0;
    exp0_q.push_back(pack(33, 6, 16'h28AC));
    start_scan(0);
    check("drive_first_en", en0, 1);
    check("drive_first_idx", {a0, b0, c0, d0}, 0);
    wait_idle(0);

    // all ones, SETTLE=2
    exp2_q.push_back(pack(65, 16, 16'hFFFF));
    start_scan(2);
    wait_idle(2);

    // all zeros with an ignored restart at cycle 10
    mode0 = 2;
    exp0_q.push_back(pack(33, 0, 16'h0000));
    start_scan(0);
    repeat (9) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0);

    // asynchronous reset at cycle 12 of a prime scan
    mode0 = 0;
    start_scan(0);
    repeat (11) @(negedge clk);
    check("pre_rst_table_nonzero", (tbl0 != 16'h0000), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_abcd", {a0, b0, c0, d0}, 0);
    check("abort_en", en0, 0);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_table", tbl0, 0);
    check("abort_ones", ones0, 0);
    @(negedge clk);
    rst = 1'b0;
    exp0_q.push_back(pack(33, 6, 16'h28AC));
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0);

    // y toggles outside SAMPLE, 0 inside SAMPLE
    mode0 = 3;
    exp0_q.push_back(pack(33, 0, 16'h0000));
    start_scan(0);
    wait_idle(0);

    // back-to-back: start in FIN is ignored, table holds, then a fresh scan
    mode0 = 0;
    exp0_q.push_back(pack(33, 6, 16'h28AC));
    start_scan(0);
    wait_fin0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("fin_start_ignored", busy0, 0);
    repeat (3) @(negedge clk);
    check("held_busy", busy0, 0);
    check("held_table", tbl0, 16'h28AC);
    check("held_ones", ones0, 6);
    check("held_abcd", {a0, b0, c0, d0}, 15);
    mode0 = 1;
    exp0_q.push_back(pack(33, 16, 16'hFFFF));
    start_scan(0);
    wait_idle(0);

    repeat (3) @(negedge clk);
    check("pending_done0", exp0_q.size(), 0);
    check("pending_done2", exp2_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
